conware_gen_sequencer: RTL
==========================

Name: conware_gen_sequencer

Overview:
- Generation scheduler for the conware Life engine.
- Holds a ROWS x 32-bit board in two internal banks (ping-pong).
- Per generation: streams the current bank to the engine slave port (AXI-Stream master side), writes the engine's returned rows into the other bank, then swaps banks.
- Repeats for a host-programmed number of generations. The host loads and reads back the board through a simple word port.

Parameters:
ROWS, 32, board rows per generation (one 32-bit word per row); power of two, 2..256
AW, 5, row address width, equal to log2(ROWS)
GEN_W, 16, width of the generation counters

Ports:
ACLK  in  1  clock, all logic on rising edge
ARESET  in  1  asynchronous, active-high reset
start  in  1  single-cycle pulse: begin running gen_count generations
gen_count  in  GEN_W  generations to run; sampled when start is accepted
busy  out  1  high from accepted start until completion
done  out  1  one-cycle pulse on completion
gens_done  out  GEN_W  generations completed in the current or last run
err_len  out  1  sticky TLAST-mismatch flag; cleared on accepted start
host_we  in  1  board word write strobe; ignored while busy
host_addr  in  AW  row index for write/read
host_wdata  in  32  row data to write into the active bank
host_rdata  out  32  active-bank row at host_addr, registered, 1-cycle latency
M_AXIS_TVALID  out  1  row-to-engine valid
M_AXIS_TDATA  out  32  row to engine
M_AXIS_TLAST  out  1  high on row ROWS-1
M_AXIS_TREADY  in  1  engine ready
S_AXIS_TVALID  in  1  result row valid
S_AXIS_TDATA  in  32  result row
S_AXIS_TLAST  in  1  result last row
S_AXIS_TREADY  out  1  sequencer ready for result row

Behaviour:
- Reset (async, active high): state=IDLE, bank_sel=0, busy=0, done=0, gens_done=0, err_len=0, M_AXIS_TVALID=0, M_AXIS_TLAST=0, S_AXIS_TREADY=0, host_rdata=0, tx_idx=rx_idx=0. Bank contents are not cleared.
- Active bank is bank[bank_sel]; the write bank is bank[~bank_sel].
- Host writes go to the active bank only in IDLE. host_rdata always reads the active bank.

State machine:
- IDLE:
  - start with gen_count!=0: latch gen_count, gens_done=0, err_len=0, go to STREAM next cycle.
  - start with gen_count==0: err_len=0, gens_done=0, done pulses the next cycle, no bus traffic.
- STREAM: send and receive proceed concurrently and independently.
  - TX:
    - M_AXIS_TVALID=1 while tx_idx<ROWS.
    - TDATA = active bank[tx_idx]; TLAST = (tx_idx==ROWS-1).
    - tx_idx increments on TVALID&TREADY.
    - TDATA/TLAST hold stable while stalled.
  - RX:
    - S_AXIS_TREADY=1 while rx_idx<ROWS.
    - On handshake: write TDATA into write bank[rx_idx], rx_idx++.
    - If S_AXIS_TLAST != (rx_idx==ROWS-1), set err_len. The row is still stored and counting continues; no resync.
  - When tx_idx==ROWS and rx_idx==ROWS, go to SWAP.
- SWAP (1 cycle):
  - Toggle bank_sel, gens_done++, clear tx_idx/rx_idx.
  - If new gens_done==latched count: go to IDLE, assert done for one cycle on IDLE entry, busy=0.
  - Otherwise return to STREAM.
- busy=1 in STREAM and SWAP.
- start while busy is ignored. Host writes while busy are dropped.
- Results may return before TX completes (pipelined engine). Ping-pong banks guarantee no read/write hazard.
- gens_done wraps modulo 2^GEN_W. gen_count=2^GEN_W-1 must complete normally.
- Reset mid-run: immediate return to reset values. Any partially received generation is lost, and bank_sel returns to 0.

Test Plan:
- Loopback stub (engine = identity, 2-cycle latency): load rows k -> 0x1000_0000+k, start with gen_count=3 -> 3x32 TX beats with TLAST on beat 32, done pulse, gens_done=3, bank_sel=1, host reads row 5 -> 0x1000_0005 one cycle later.
- Real conware engine, ROWS=32: row 10=0x0000_0E00 (horizontal blinker), all other rows 0, gen_count=1 -> rows 9,10,11 read 0x0000_0400; gen_count=2 restores row 10=0x0000_0E00, rows 9/11=0.
- Backpressure: M_AXIS_TREADY random 30% high, S_AXIS_TVALID bursty -> TDATA stable across every stall, no lost or duplicated rows, results identical to the no-stall run.
- gen_count=0 -> done pulse one cycle after start, busy never high, zero TVALID cycles; start pulsed while busy -> ignored, gens_done still ends at the original count.
- Stub asserts S_AXIS_TLAST on row 7 and not on row 31 -> err_len=1 after run; next accepted start clears err_len to 0.
- ARESET asserted mid-STREAM of generation 2 -> all outputs at reset values in the same cycle; new start with gen_count=1 completes normally with bank_sel 0->1.

Source files
------------

// File: rtl/conware_gen_sequencer.sv
// Generation scheduler for the conware Life engine: ping-pongs a ROWS x 32 board
// through the engine over AXI-Stream for a host-programmed number of generations.
module conware_gen_sequencer #(
    parameter int ROWS  = 32,
    parameter int AW    = 5,
    parameter int GEN_W = 16
) (
    input  logic             ACLK,
    input  logic             ARESET,
    input  logic             start,
    input  logic [GEN_W-1:0] gen_count,
    output logic             busy,
    output logic             done,
    output logic [GEN_W-1:0] gens_done,
    output logic             err_len,
    input  logic             host_we,
    input  logic [AW-1:0]    host_addr,
    input  logic [31:0]      host_wdata,
    output logic [31:0]      host_rdata,
    output logic             M_AXIS_TVALID,
    output logic [31:0]      M_AXIS_TDATA,
    output logic             M_AXIS_TLAST,
    input  logic             M_AXIS_TREADY,
    input  logic             S_AXIS_TVALID,
    input  logic [31:0]      S_AXIS_TDATA,
    input  logic             S_AXIS_TLAST,
    output logic             S_AXIS_TREADY
);

    typedef enum logic [1:0] {IDLE, STREAM, SWAP} state_t;

    localparam logic [AW:0] ROWS_IDX = (AW+1)'(ROWS);
    localparam logic [AW:0] LAST_IDX = ROWS_IDX - 1'b1;

    state_t           state;
    logic             bank_sel;
    logic             wr_sel;
    logic [AW:0]      tx_idx;
    logic [AW:0]      rx_idx;
    logic [AW:0]      tx_idx_nx;
    logic [AW:0]      rx_idx_nx;
    logic [GEN_W-1:0] gen_target;
    logic [GEN_W-1:0] gens_done_nx;
    logic             tx_fire;
    logic             rx_fire;
    logic             host_wr;
    logic [31:0]      bank [2][ROWS];

    always_comb begin
        tx_fire      = M_AXIS_TVALID & M_AXIS_TREADY;
        rx_fire      = S_AXIS_TVALID & S_AXIS_TREADY;
        tx_idx_nx    = tx_idx + 1'b1;
        rx_idx_nx    = rx_idx + 1'b1;
        gens_done_nx = gens_done + 1'b1;
        wr_sel       = ~bank_sel;
        host_wr      = host_we & (state == IDLE);
    end

    // The active bank is never written while streaming, so TDATA is stable across stalls.
    assign M_AXIS_TDATA = bank[bank_sel][tx_idx[AW-1:0]];

    always_ff @(posedge ACLK) begin
        if (host_wr)
            bank[bank_sel][host_addr] <= host_wdata;
        if (rx_fire)
            bank[wr_sel][rx_idx[AW-1:0]] <= S_AXIS_TDATA;
    end

    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET)
            host_rdata <= '0;
        else
            host_rdata <= bank[bank_sel][host_addr];
    end

    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            state         <= IDLE;
            bank_sel      <= 1'b0;
            busy          <= 1'b0;
            done          <= 1'b0;
            gens_done     <= '0;
            gen_target    <= '0;
            err_len       <= 1'b0;
            tx_idx        <= '0;
            rx_idx        <= '0;
            M_AXIS_TVALID <= 1'b0;
            M_AXIS_TLAST  <= 1'b0;
            S_AXIS_TREADY <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        err_len   <= 1'b0;
                        gens_done <= '0;
                        if (gen_count != '0) begin
                            gen_target    <= gen_count;
                            state         <= STREAM;
                            busy          <= 1'b1;
                            tx_idx        <= '0;
                            rx_idx        <= '0;
                            M_AXIS_TVALID <= 1'b1;
                            M_AXIS_TLAST  <= 1'b0;
                            S_AXIS_TREADY <= 1'b1;
                        end else begin
                            done <= 1'b1;
                        end
                    end
                end
                STREAM: begin
                    if (tx_fire) begin
                        tx_idx        <= tx_idx_nx;
                        M_AXIS_TVALID <= (tx_idx_nx != ROWS_IDX);
                        M_AXIS_TLAST  <= (tx_idx_nx == LAST_IDX);
                    end
                    // A misplaced TLAST is only flagged; the row is kept and counting goes on.
                    if (rx_fire) begin
                        rx_idx        <= rx_idx_nx;
                        S_AXIS_TREADY <= (rx_idx_nx != ROWS_IDX);
                        if (S_AXIS_TLAST != (rx_idx == LAST_IDX))
                            err_len <= 1'b1;
                    end
                    if (tx_idx == ROWS_IDX && rx_idx == ROWS_IDX)
                        state <= SWAP;
                end
                SWAP: begin
                    bank_sel  <= ~bank_sel;
                    gens_done <= gens_done_nx;
                    tx_idx    <= '0;
                    rx_idx    <= '0;
                    if (gens_done_nx == gen_target) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end else begin
                        state         <= STREAM;
                        M_AXIS_TVALID <= 1'b1;
                        M_AXIS_TLAST  <= 1'b0;
                        S_AXIS_TREADY <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
